// File: rtl/systolic_feeder_pkg.sv
// Shared types and defaults for the systolic array edge feeder.
// State encodings are fixed 3-bit values so other blocks can decode them.
package systolic_feeder_pkg;

  localparam int DEFAULT_DATA_WIDTH = 10;
  localparam int DEFAULT_N          = 4;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    CLEAR  = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } feed_state_t;

  // True when lane `lane` carries a real operand at stream step t.
  function automatic logic skew_hit(input int t, input int lane, input int n);
    return (t >= lane) && ((t - lane) < n);
  endfunction

endpackage

// File: rtl/feeder_matrix_buf.sv
// NxN operand register file: one synchronous write port, N combinational
// read ports addressed by (row,col). Contents are deliberately not reset.
module feeder_matrix_buf
  import systolic_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = DEFAULT_N,
  localparam int AW        = $clog2(N*N),
  localparam int IW        = $clog2(N)
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [AW-1:0]                  waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [N-1:0][IW-1:0]           rd_row,
  input  logic [N-1:0][IW-1:0]           rd_col,
  output logic [N-1:0][DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:N*N-1];
  logic [N-1:0][AW-1:0]  raddr;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    for (int p = 0; p < N; p++) begin
      raddr[p]   = AW'(int'(rd_row[p]) * N + int'(rd_col[p]));
      rd_data[p] = mem[raddr[p]];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers A then B from the load stream, clears the PE grid for one cycle, then
// streams both matrices diagonally skewed onto the west/north array edges.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = DEFAULT_N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [DATA_WIDTH-1:0]   ld_data,
  output logic [N*DATA_WIDTH-1:0] a_edge,
  output logic [N*DATA_WIDTH-1:0] b_edge,
  output logic                    pe_rst_n,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ack
);

  localparam int LW     = $clog2(N*N);
  localparam int TW     = $clog2(3*N-2);
  localparam int IW     = $clog2(N);
  localparam int LAST_L = N*N - 1;
  localparam int LAST_T = 3*N - 3;

  feed_state_t    state_q, state_d;
  logic [LW-1:0]  lcnt_q, lcnt_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           ld_fire, a_we, b_we;

  logic [N-1:0][IW-1:0]         a_row, a_col, b_row, b_col;
  logic [N-1:0]                 a_hit, b_hit;
  logic [N-1:0][DATA_WIDTH-1:0] a_rd, b_rd;
  logic [N*DATA_WIDTH-1:0]      a_edge_d, b_edge_d;

  assign ld_fire = ld_valid && ld_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD_A;
      lcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    tcnt_d  = tcnt_q;
    a_we    = 1'b0;
    b_we    = 1'b0;
    unique case (state_q)
      LOAD_A: begin
        if (ld_fire) begin
          a_we = 1'b1;
          if (lcnt_q == LW'(LAST_L)) begin
            state_d = LOAD_B;
            lcnt_d  = '0;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (ld_fire) begin
          b_we = 1'b1;
          if (lcnt_q == LW'(LAST_L)) begin
            state_d = CLEAR;
            lcnt_d  = '0;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = STREAM;
        tcnt_d  = '0;
      end
      STREAM: begin
        if (tcnt_q == TW'(LAST_T)) begin
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ack) begin
          state_d = LOAD_A;
          lcnt_d  = '0;
        end
      end
      default: begin
        state_d = LOAD_A;
        lcnt_d  = '0;
        tcnt_d  = '0;
      end
    endcase
  end

  // Skew addressing uses the next step count so the edge registers line up with the state.
  always_comb begin
    for (int p = 0; p < N; p++) begin
      a_hit[p] = skew_hit(int'(tcnt_d), p, N);
      b_hit[p] = a_hit[p];
      a_row[p] = IW'(p);
      a_col[p] = a_hit[p] ? IW'(int'(tcnt_d) - p) : '0;
      b_row[p] = b_hit[p] ? IW'(int'(tcnt_d) - p) : '0;
      b_col[p] = IW'(p);
    end
  end

  feeder_matrix_buf #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_buf_a (
    .clk     (clk),
    .we      (a_we),
    .waddr   (lcnt_q),
    .wdata   (ld_data),
    .rd_row  (a_row),
    .rd_col  (a_col),
    .rd_data (a_rd)
  );

  feeder_matrix_buf #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_buf_b (
    .clk     (clk),
    .we      (b_we),
    .waddr   (lcnt_q),
    .wdata   (ld_data),
    .rd_row  (b_row),
    .rd_col  (b_col),
    .rd_data (b_rd)
  );

  always_comb begin
    a_edge_d = '0;
    b_edge_d = '0;
    for (int p = 0; p < N; p++) begin
      if (state_d == STREAM && a_hit[p]) begin
        a_edge_d[p*DATA_WIDTH +: DATA_WIDTH] = a_rd[p];
      end
      if (state_d == STREAM && b_hit[p]) begin
        b_edge_d[p*DATA_WIDTH +: DATA_WIDTH] = b_rd[p];
      end
    end
  end

  // Outputs are registered from the next-state view so they always match state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_ready  <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      pe_rst_n  <= 1'b0;
      a_edge    <= '0;
      b_edge    <= '0;
    end else begin
      ld_ready  <= (state_d == LOAD_A) || (state_d == LOAD_B);
      busy      <= (state_d == CLEAR) || (state_d == STREAM);
      res_valid <= (state_d == DONE);
      pe_rst_n  <= (state_d != CLEAR);
      a_edge    <= a_edge_d;
      b_edge    <= b_edge_d;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench: N=2 and N=4 feeders, each driving a behavioural output-stationary PE grid.
module tb_systolic_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] ld_data = '0;
  logic ld_valid2 = 1'b0, res_ack2 = 1'b0;
  logic ld_valid4 = 1'b0, res_ack4 = 1'b0;

  logic        ld_ready2, pe2, busy2, rv2;
  logic [19:0] a_edge2, b_edge2;
  logic        ld_ready4, pe4, busy4, rv4;
  logic [39:0] a_edge4, b_edge4;

  int checks = 0;
  int errors = 0;
  int acc_cnt2 = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_WIDTH(10), .N(2)) u_dut2 (
    .clk(clk), .rst(rst), .ld_valid(ld_valid2), .ld_ready(ld_ready2), .ld_data(ld_data),
    .a_edge(a_edge2), .b_edge(b_edge2), .pe_rst_n(pe2), .busy(busy2),
    .res_valid(rv2), .res_ack(res_ack2)
  );

  systolic_feeder #(.DATA_WIDTH(10), .N(4)) u_dut4 (
    .clk(clk), .rst(rst), .ld_valid(ld_valid4), .ld_ready(ld_ready4), .ld_data(ld_data),
    .a_edge(a_edge4), .b_edge(b_edge4), .pe_rst_n(pe4), .busy(busy4),
    .res_valid(rv4), .res_ack(res_ack4)
  );

  always @(posedge clk) if (ld_valid2 && ld_ready2) acc_cnt2++;

  // Output-stationary PE grids: a flows east, b flows south, acc += a*b.
  int unsigned acc2[2][2], ar2[2][2], br2[2][2];
  always @(posedge clk or negedge pe2) begin
    if (!pe2) begin
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
        acc2[i][j] <= 0; ar2[i][j] <= 0; br2[i][j] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
        int unsigned ai, bi;
        if (j == 0) ai = 32'(a_edge2[i*10 +: 10]); else ai = ar2[i][j-1];
        if (i == 0) bi = 32'(b_edge2[j*10 +: 10]); else bi = br2[i-1][j];
        acc2[i][j] <= acc2[i][j] + ai * bi;
        ar2[i][j]  <= ai;
        br2[i][j]  <= bi;
      end
    end
  end

  int unsigned acc4[4][4], ar4[4][4], br4[4][4];
  always @(posedge clk or negedge pe4) begin
    if (!pe4) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
        acc4[i][j] <= 0; ar4[i][j] <= 0; br4[i][j] <= 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
        int unsigned ai, bi;
        if (j == 0) ai = 32'(a_edge4[i*10 +: 10]); else ai = ar4[i][j-1];
        if (i == 0) bi = 32'(b_edge4[j*10 +: 10]); else bi = br4[i-1][j];
        acc4[i][j] <= acc4[i][j] + ai * bi;
        ar4[i][j]  <= ai;
        br4[i][j]  <= bi;
      end
    end
  end

  typedef struct {
    logic [19:0] a;
    logic [19:0] b;
    logic        pe;
    logic        busy;
    logic        rv;
    logic        rdy;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [9:0] v);
    int b = 0;
    ld_valid2 = 1'b1;
    ld_data   = v;
    while (!ld_ready2 && b < 20) begin step(); b++; end
    if (b >= 20) chk("push2_timeout", 64'(ld_ready2), 64'd1);
    step();
    ld_valid2 = 1'b0;
  endtask

  task automatic push4(input logic [9:0] v);
    int b = 0;
    ld_valid4 = 1'b1;
    ld_data   = v;
    while (!ld_ready4 && b < 20) begin step(); b++; end
    if (b >= 20) chk("push4_timeout", 64'(ld_ready4), 64'd1);
    step();
    ld_valid4 = 1'b0;
  endtask

  task automatic load2(input logic [9:0] w0, w1, w2, w3, w4, w5, w6, w7, input bit toggle);
    logic [9:0] w[8];
    w = '{w0, w1, w2, w3, w4, w5, w6, w7};
    for (int k = 0; k < 8; k++) begin
      push2(w[k]);
      if (toggle && k < 7) step();
    end
  endtask

  // Entered right after the last load handshake: CLEAR, t0..t3, DONE.
  task automatic run_table(input string tag);
    for (int e = 0; e < 6; e++) begin
      if (e > 0) step();
      chk($sformatf("%s_a%0d", tag, e),    64'(a_edge2), 64'(tbl[e].a));
      chk($sformatf("%s_b%0d", tag, e),    64'(b_edge2), 64'(tbl[e].b));
      chk($sformatf("%s_pe%0d", tag, e),   64'(pe2),     64'(tbl[e].pe));
      chk($sformatf("%s_busy%0d", tag, e), 64'(busy2),   64'(tbl[e].busy));
      chk($sformatf("%s_rv%0d", tag, e),   64'(rv2),     64'(tbl[e].rv));
      chk($sformatf("%s_rdy%0d", tag, e),  64'(ld_ready2), 64'(tbl[e].rdy));
    end
  endtask

  task automatic wait_done2(input string tag);
    int b = 0;
    while (!rv2 && b < 30) begin step(); b++; end
    chk({tag, "_done"}, 64'(rv2), 64'd1);
  endtask

  task automatic check_c2(input string tag, input int unsigned c00, c01, c10, c11);
    chk({tag, "_c00"}, 64'(acc2[0][0]), 64'(c00));
    chk({tag, "_c01"}, 64'(acc2[0][1]), 64'(c01));
    chk({tag, "_c10"}, 64'(acc2[1][0]), 64'(c10));
    chk({tag, "_c11"}, 64'(acc2[1][1]), 64'(c11));
  endtask

  initial begin
    int c0;
    int scnt;
    tbl[0] = '{20'd0, 20'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{{10'd0, 10'd1}, {10'd0, 10'd5}, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{{10'd3, 10'd2}, {10'd6, 10'd7}, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{{10'd4, 10'd0}, {10'd8, 10'd0}, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{20'd0, 20'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{20'd0, 20'd0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset values
    #1 rst = 1'b0;
    #2;
    chk("rst_rdy", 64'(ld_ready2), 64'd1);
    chk("rst_busy", 64'(busy2), 64'd0);
    chk("rst_rv", 64'(rv2), 64'd0);
    chk("rst_pe", 64'(pe2), 64'd0);
    chk("rst_edges", 64'({a_edge2, b_edge2}), 64'd0);
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_pe_release", 64'(pe2), 64'd1);

    // 1+2: back-to-back load, skewed edges, PE results
    acc_cnt2 = 0;
    load2(10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 1'b0);
    chk("t1_handshakes", 64'(acc_cnt2), 64'd8);
    run_table("t1");
    check_c2("t2", 19, 22, 43, 50);
    res_ack2 = 1'b0;
    step(); step();
    chk("t2_hold_done", 64'(rv2), 64'd1);
    res_ack2 = 1'b1;
    step();
    res_ack2 = 1'b0;
    chk("t2_ack_rv", 64'(rv2), 64'd0);
    chk("t2_ack_rdy", 64'(ld_ready2), 64'd1);

    // 3: ld_valid toggling
    acc_cnt2 = 0;
    load2(10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 1'b1);
    chk("t3_handshakes", 64'(acc_cnt2), 64'd8);
    run_table("t3");
    check_c2("t3", 19, 22, 43, 50);
    res_ack2 = 1'b1;
    step();
    res_ack2 = 1'b0;

    // 4: reset mid-stream, then identity run
    load2(10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 1'b0);
    step(); step();
    chk("t4_a_t1", 64'(a_edge2), 64'({10'd3, 10'd2}));
    rst = 1'b0;
    #1;
    chk("t4_rst_edges", 64'({a_edge2, b_edge2}), 64'd0);
    chk("t4_rst_pe", 64'(pe2), 64'd0);
    chk("t4_rst_rv", 64'(rv2), 64'd0);
    chk("t4_rst_busy", 64'(busy2), 64'd0);
    chk("t4_rst_rdy", 64'(ld_ready2), 64'd1);
    chk("t4_grid_cleared", 64'(acc2[0][0]), 64'd0);
    step();
    rst = 1'b1;
    step();
    chk("t4_pe_release", 64'(pe2), 64'd1);
    load2(10'd1, 10'd0, 10'd0, 10'd1, 10'd9, 10'd8, 10'd7, 10'd6, 1'b0);
    wait_done2("t4");
    check_c2("t4", 9, 8, 7, 6);

    // 5: res_ack with ld_valid in DONE, then all-ones run
    c0 = acc_cnt2;
    res_ack2  = 1'b1;
    ld_valid2 = 1'b1;
    ld_data   = 10'd1;
    step();
    res_ack2  = 1'b0;
    ld_valid2 = 1'b0;
    chk("t5_no_accept_in_done", 64'(acc_cnt2), 64'(c0));
    chk("t5_rdy_after_ack", 64'(ld_ready2), 64'd1);
    chk("t5_rv_after_ack", 64'(rv2), 64'd0);
    load2(10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 1'b0);
    chk("t5_handshakes", 64'(acc_cnt2 - c0), 64'd8);
    wait_done2("t5");
    check_c2("t5", 2, 2, 2, 2);
    res_ack2 = 1'b1;
    step();
    res_ack2 = 1'b0;

    // 6: N=4 full-scale operands
    for (int k = 0; k < 32; k++) push4(10'd1023);
    chk("t6_clear_pe", 64'(pe4), 64'd0);
    chk("t6_clear_busy", 64'(busy4), 64'd1);
    scnt = 0;
    for (int b = 0; b < 40 && !rv4; b++) begin
      step();
      if (scnt == 0 && busy4)
        chk("t6_a_t0", 64'(a_edge4), 64'({10'd0, 10'd0, 10'd0, 10'd1023}));
      if (busy4 && pe4) scnt++;
    end
    chk("t6_done", 64'(rv4), 64'd1);
    chk("t6_stream_len", 64'(scnt), 64'd10);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++)
      chk($sformatf("t6_c%0d%0d", i, j), 64'(acc4[i][j]), 64'd4186116);
    res_ack4 = 1'b1;
    step();
    res_ack4 = 1'b0;
    chk("t6_ack_rdy", 64'(ld_ready4), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
